// File: rtl/tft_ili9341_region_sched.sv
// Region write scheduler for the ILI9341: round-robin arbitration between two rectangle
// requesters, then CASET/PASET/RAMWR with coordinates followed by RGB565 pixel bytes.
module tft_ili9341_region_sched #(
    parameter int TFT_WIDTH  = 320,
    parameter int TFT_HEIGHT = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic [1:0]  req_valid,
    input  logic [35:0] req_rect0,
    input  logic [35:0] req_rect1,
    output logic [1:0]  req_ack,
    output logic [1:0]  req_err,
    output logic        grant,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [8:0]  spi_data,
    output logic        spi_data_set,
    input  logic        spi_idle,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_CMD,
        S_PIX_HI,
        S_PIX_LO,
        S_DONE
    } state_t;

    localparam logic [8:0] X_LIM = 9'(TFT_WIDTH);
    localparam logic [8:0] Y_LIM = 9'(TFT_HEIGHT);

    state_t      state_q, state_d;
    logic [35:0] rect_q, rect_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cmd_idx_q, cmd_idx_d;
    logic [16:0] count_q, count_d;
    logic [7:0]  low_q, low_d;
    logic [8:0]  spi_data_q, spi_data_d;
    logic        spi_set_q, spi_set_d;

    logic        issue;
    logic        sel;
    logic [35:0] sel_rect;
    logic [8:0]  sx0, sx1, sy0, sy1;
    logic [9:0]  sel_w, sel_h;
    logic        rect_bad;
    logic [8:0]  cmd_byte;

    // A byte may only go out when the sender is idle and we did not strobe last cycle.
    assign issue = spi_idle && !spi_set_q;

    always_comb begin
        case (req_valid)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            default: sel = !last_grant_q;
        endcase
    end

    assign sel_rect = sel ? req_rect1 : req_rect0;
    assign sx0      = sel_rect[35:27];
    assign sx1      = sel_rect[26:18];
    assign sy0      = sel_rect[17:9];
    assign sy1      = sel_rect[8:0];
    assign sel_w    = {1'b0, sx1} - {1'b0, sx0} + 10'd1;
    assign sel_h    = {1'b0, sy1} - {1'b0, sy0} + 10'd1;
    assign rect_bad = (sx0 > sx1) || (sy0 > sy1) || (sx1 >= X_LIM) || (sy1 >= Y_LIM);

    always_comb begin
        case (cmd_idx_q)
            4'd0:    cmd_byte = {1'b0, 8'h2A};
            4'd1:    cmd_byte = {1'b1, 7'd0, rect_q[35]};
            4'd2:    cmd_byte = {1'b1, rect_q[34:27]};
            4'd3:    cmd_byte = {1'b1, 7'd0, rect_q[26]};
            4'd4:    cmd_byte = {1'b1, rect_q[25:18]};
            4'd5:    cmd_byte = {1'b0, 8'h2B};
            4'd6:    cmd_byte = {1'b1, 7'd0, rect_q[17]};
            4'd7:    cmd_byte = {1'b1, rect_q[16:9]};
            4'd8:    cmd_byte = {1'b1, 7'd0, rect_q[8]};
            4'd9:    cmd_byte = {1'b1, rect_q[7:0]};
            default: cmd_byte = {1'b0, 8'h2C};
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rect_d       = rect_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cmd_idx_d    = cmd_idx_q;
        count_d      = count_q;
        low_d        = low_q;
        spi_data_d   = spi_data_q;
        spi_set_d    = 1'b0;
        req_ack      = 2'b00;
        req_err      = 2'b00;
        pix_ready    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (init_done && (|req_valid)) state_d = S_ARB;
            end
            S_ARB: begin
                if (req_valid == 2'b00) begin
                    state_d = S_IDLE;
                end else begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    rect_d       = sel_rect;
                    if (rect_bad) begin
                        req_err[sel] = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        req_ack[sel] = 1'b1;
                        cmd_idx_d    = 4'd0;
                        count_d      = 17'(sel_w) * 17'(sel_h);
                        state_d      = S_CMD;
                    end
                end
            end
            S_CMD: begin
                if (issue) begin
                    spi_set_d  = 1'b1;
                    spi_data_d = cmd_byte;
                    if (cmd_idx_q == 4'd10) begin
                        cmd_idx_d = 4'd0;
                        state_d   = S_PIX_HI;
                    end else begin
                        cmd_idx_d = cmd_idx_q + 4'd1;
                    end
                end
            end
            S_PIX_HI: begin
                if (issue && pix_valid) begin
                    spi_set_d  = 1'b1;
                    spi_data_d = {1'b1, pix_data[15:8]};
                    low_d      = pix_data[7:0];
                    pix_ready  = 1'b1;
                    state_d    = S_PIX_LO;
                end
            end
            S_PIX_LO: begin
                if (issue) begin
                    spi_set_d  = 1'b1;
                    spi_data_d = {1'b1, low_q};
                    count_d    = count_q - 17'd1;
                    state_d    = (count_q == 17'd1) ? S_DONE : S_PIX_HI;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rect_q       <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cmd_idx_q    <= '0;
            count_q      <= '0;
            low_q        <= '0;
            spi_data_q   <= '0;
            spi_set_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rect_q       <= rect_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cmd_idx_q    <= cmd_idx_d;
            count_q      <= count_d;
            low_q        <= low_d;
            spi_data_q   <= spi_data_d;
            spi_set_q    <= spi_set_d;
        end
    end

    assign spi_data     = spi_data_q;
    assign spi_data_set = spi_set_q;
    assign grant        = (state_q == S_ARB) ? sel : grant_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_tft_ili9341_region_sched.sv
// Bench for tft_ili9341_region_sched: directed and randomized region requests, with the
// expected SPI byte stream and grant order built from the rectangle rules by a queue model.
module tb_tft_ili9341_region_sched;
    localparam int W = 320;
    localparam int H = 240;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic [1:0]  req_valid;
    logic [35:0] req_rect0, req_rect1;
    logic [1:0]  req_ack, req_err;
    logic        grant;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [8:0]  spi_data;
    logic        spi_data_set;
    logic        spi_idle;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    tft_ili9341_region_sched #(.TFT_WIDTH(W), .TFT_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req_valid(req_valid), .req_rect0(req_rect0), .req_rect1(req_rect1),
        .req_ack(req_ack), .req_err(req_err), .grant(grant),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .spi_data(spi_data), .spi_data_set(spi_data_set), .spi_idle(spi_idle),
        .busy(busy), .done(done)
    );

    int n_compared = 0;
    int n_mismatched = 0;

    logic [15:0] pix_mem [1024];
    int   pix_idx = 0;
    bit   pop_pending = 1'b0;
    bit [1:0] clr_pending = 2'b00;
    bit   pix_gap = 1'b0;
    bit   idle_random = 1'b0;
    int   stall_at = -1;
    int   stall_left = 0;
    int   ready_cnt = 0, done_cnt = 0, strobe_cnt = 0, proto_viol = 0;
    bit   prev_idle = 1'b0, prev_set = 1'b0;

    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];
    int   ack_obs[$];
    int   ack_exp[$];
    int   exp_pix = 0;
    bit   model_last = 1'b1;

    // Observer: samples mid-cycle, records strobes, handshakes and the issue-rule violations.
    always @(negedge clk) begin
        if (spi_data_set) begin
            obs_q.push_back(spi_data);
            strobe_cnt++;
            if (!prev_idle || prev_set) proto_viol++;
        end
        prev_idle = spi_idle;
        prev_set  = spi_data_set;
        pop_pending = pix_ready;
        if (pix_ready) ready_cnt++;
        if (done) done_cnt++;
        for (int p = 0; p < 2; p++) begin
            if (req_ack[p]) ack_obs.push_back(p);
            if (req_err[p]) ack_obs.push_back(p + 2);
        end
        clr_pending = req_ack | req_err;
    end

    // Environment: requesters drop valid after ack/err, pixel source, SPI idle model.
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < 2; p++)
            if (clr_pending[p]) req_valid[p] = 1'b0;
        if (pop_pending) pix_idx++;
        pix_data  = pix_mem[pix_idx % 1024];
        pix_valid = pix_gap ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stall_at >= 0 && ready_cnt == stall_at) begin
            stall_left = 5;
            stall_at   = -1;
        end
        if (stall_left > 0) begin
            spi_idle = 1'b0;
            stall_left--;
        end else begin
            spi_idle = idle_random ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    function automatic logic [35:0] makeRect(input int x0, input int x1, input int y0, input int y1);
        return {9'(x0), 9'(x1), 9'(y0), 9'(y1)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: one served request expands into its handshake and byte sequence.
    task automatic modelServe(input int p, input logic [35:0] r);
        int c[4];
        int n;
        int v;
        logic [15:0] px;
        c[0] = int'(r[35:27]);
        c[1] = int'(r[26:18]);
        c[2] = int'(r[17:9]);
        c[3] = int'(r[8:0]);
        model_last = (p == 1);
        if (c[0] > c[1] || c[2] > c[3] || c[1] >= W || c[3] >= H) begin
            ack_exp.push_back(p + 2);
            return;
        end
        ack_exp.push_back(p);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b0, (k == 0) ? 8'h2A : 8'h2B});
            for (int j = 0; j < 2; j++) begin
                v = c[2 * k + j];
                exp_q.push_back({1'b1, 8'(v / 256)});
                exp_q.push_back({1'b1, 8'(v % 256)});
            end
        end
        exp_q.push_back(9'h02C);
        n = (c[1] - c[0] + 1) * (c[3] - c[2] + 1);
        for (int i = 0; i < n; i++) begin
            px = pix_mem[exp_pix % 1024];
            exp_q.push_back({1'b1, px[15:8]});
            exp_q.push_back({1'b1, px[7:0]});
            exp_pix++;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mask, input logic [35:0] r0, input logic [35:0] r1);
        int first;
        @(posedge clk);
        #1;
        req_rect0 = r0;
        req_rect1 = r1;
        req_valid = mask;
        if (mask == 2'b11) begin
            first = model_last ? 0 : 1;
            modelServe(first, (first == 0) ? r0 : r1);
            modelServe(1 - first, (first == 0) ? r1 : r0);
        end else if (mask[0]) begin
            modelServe(0, r0);
        end else begin
            modelServe(1, r1);
        end
    endtask

    task automatic waitIdle(input string tag);
        int cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while ((req_valid != 2'b00 || busy) && cyc < 20000);
        checkOutput({tag, "_finished_in_time"}, 32'(cyc < 20000), 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic waitReady(input int target, input string tag);
        int cyc = 0;
        while (ready_cnt < target && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, "_ready_reached"}, 32'(ready_cnt >= target), 32'd1);
    endtask

    task automatic flushAll();
        obs_q.delete();
        exp_q.delete();
        ack_obs.delete();
        ack_exp.delete();
        exp_pix = pix_idx;
    endtask

    task automatic checkStreams(input string tag, input bit prefix_only);
        int bad = -1;
        if (prefix_only)
            checkOutput({tag, "_len_within"}, 32'(obs_q.size() <= exp_q.size()), 32'd1);
        else
            checkOutput({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
        if (bad >= 0)
            $display("[TB] %s first differing byte %0d: got %h want %h", tag, bad, obs_q[bad], exp_q[bad]);
        checkOutput({tag, "_first_bad_idx"}, 32'(bad), 32'hFFFF_FFFF);
        checkOutput({tag, "_ack_count"}, 32'(ack_obs.size()), 32'(ack_exp.size()));
        for (int i = 0; i < ack_obs.size() && i < ack_exp.size(); i++)
            checkOutput({tag, "_ack_order"}, 32'(ack_obs[i]), 32'(ack_exp[i]));
        checkOutput({tag, "_issue_rule"}, 32'(proto_viol), 32'd0);
        flushAll();
    endtask

    task automatic pulseReset(input string tag);
        int s0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s0 = strobe_cnt;
        checkOutput({tag, "_spi_set"}, 32'(spi_data_set), 32'd0);
        checkOutput({tag, "_spi_data"}, 32'(spi_data), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
        checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput({tag, "_quiet_after"}, 32'(strobe_cnt - s0), 32'd0);
        model_last = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base_r, base_d, base_s, mask, x0, x1, y0, y1, w, h, t;
        logic [35:0] ra, rb;

        rst = 1'b1; init_done = 1'b0; req_valid = 2'b00;
        req_rect0 = '0; req_rect1 = '0; pix_data = '0; pix_valid = 1'b0; spi_idle = 1'b1;
        for (int i = 0; i < 1024; i++) pix_mem[i] = 16'($urandom);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_spi_set", 32'(spi_data_set), 32'd0);
        checkOutput("rst_spi_data", 32'(spi_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_ack", 32'(req_ack), 32'd0);
        checkOutput("rst_err", 32'(req_err), 32'd0);
        checkOutput("rst_pix_ready", 32'(pix_ready), 32'd0);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        flushAll();

        // init_done gates arbitration, then single-pixel transfer
        pix_mem[pix_idx % 1024] = 16'hF81F;
        base_r = ready_cnt; base_d = done_cnt;
        applyStimulus(2'b01, makeRect(0, 0, 0, 0), '0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("init_gate_busy", 32'(busy), 32'd0);
        checkOutput("init_gate_strobes", 32'(obs_q.size()), 32'd0);
        init_done = 1'b1;
        waitIdle("t1");
        checkOutput("t1_first_cmd", 32'(obs_q[0]), 32'h02A);
        checkOutput("t1_ramwr", 32'(obs_q[10]), 32'h02C);
        checkOutput("t1_pix_hi", 32'(obs_q[11]), 32'h1F8);
        checkOutput("t1_pix_lo", 32'(obs_q[12]), 32'h11F);
        checkOutput("t1_pix_ready", 32'(ready_cnt - base_r), 32'd1);
        checkOutput("t1_done", 32'(done_cnt - base_d), 32'd1);
        checkStreams("t1", 1'b0);

        // Simultaneous requests right after reset: port0 wins the first tie
        pulseReset("rst_a");
        flushAll();
        applyStimulus(2'b11, makeRect(1, 2, 3, 3), makeRect(4, 4, 5, 6));
        waitIdle("t2a");
        checkOutput("t2a_first_port", 32'(ack_obs[0]), 32'd0);
        checkOutput("t2a_second_port", 32'(ack_obs[1]), 32'd1);
        checkStreams("t2a", 1'b0);
        applyStimulus(2'b01, makeRect(7, 8, 1, 1), '0);
        waitIdle("t2b");
        checkStreams("t2b", 1'b0);
        applyStimulus(2'b11, makeRect(9, 9, 9, 10), makeRect(2, 3, 2, 2));
        waitIdle("t2c");
        checkOutput("t2c_first_port", 32'(ack_obs[0]), 32'd1);
        checkOutput("t2c_second_port", 32'(ack_obs[1]), 32'd0);
        checkStreams("t2c", 1'b0);

        // Rejected rectangles and the valid corner case
        base_s = strobe_cnt;
        applyStimulus(2'b01, makeRect(10, 5, 0, 0), '0);
        waitIdle("t3");
        checkOutput("t3_err_port0", 32'(ack_obs[0]), 32'd2);
        checkOutput("t3_no_strobes", 32'(strobe_cnt - base_s), 32'd0);
        checkStreams("t3", 1'b0);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: ra = makeRect(0, 320, 0, 0);
                1: ra = makeRect(0, 0, 0, 240);
                2: ra = makeRect(0, 0, 7, 6);
                default: ra = makeRect(319, 319, 239, 239);
            endcase
            applyStimulus(2'b10, '0, ra);
            waitIdle("t3b");
            checkStreams("t3b", 1'b0);
        end

        // Full-width row and full-height column, then a full-screen header cut short by reset
        applyStimulus(2'b01, makeRect(0, 319, 239, 239), '0);
        waitIdle("t4row");
        checkStreams("t4row", 1'b0);
        applyStimulus(2'b10, '0, makeRect(0, 0, 0, 239));
        waitIdle("t4col");
        checkStreams("t4col", 1'b0);
        base_r = ready_cnt;
        applyStimulus(2'b10, '0, makeRect(0, 319, 0, 239));
        waitReady(base_r + 20, "t4full");
        pulseReset("rst_b");
        checkOutput("t4_caset_x1_hi", 32'(obs_q[3]), 32'h101);
        checkOutput("t4_caset_x1_lo", 32'(obs_q[4]), 32'h13F);
        checkOutput("t4_paset_y1_hi", 32'(obs_q[8]), 32'h100);
        checkOutput("t4_paset_y1_lo", 32'(obs_q[9]), 32'h1EF);
        checkOutput("t4_enough_bytes", 32'(obs_q.size() >= 50), 32'd1);
        checkStreams("t4full", 1'b1);

        // SPI stall in PIX_LO and a stuttering pixel source
        pix_gap = 1'b1;
        stall_at = ready_cnt + 5;
        applyStimulus(2'b01, makeRect(20, 23, 30, 33), '0);
        waitIdle("t5");
        checkStreams("t5", 1'b0);
        pix_gap = 1'b0;

        // Reset at pixel 3 of 8, then a fresh request starts over at CASET
        base_r = ready_cnt;
        applyStimulus(2'b01, makeRect(0, 7, 0, 0), '0);
        waitReady(base_r + 3, "t6");
        pulseReset("rst_c");
        flushAll();
        applyStimulus(2'b10, '0, makeRect(2, 3, 4, 4));
        waitIdle("t6new");
        checkOutput("t6_restart_caset", 32'(obs_q[0]), 32'h02A);
        checkStreams("t6new", 1'b0);

        // Randomized requests, pixel gaps and SPI back-pressure
        for (int it = 0; it < 12; it++) begin
            pix_gap = 1'($urandom_range(0, 1));
            idle_random = 1'($urandom_range(0, 1));
            mask = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                x0 = $urandom_range(0, 318);
                w  = $urandom_range(1, 4);
                x1 = x0 + w - 1;
                y0 = $urandom_range(0, 238);
                h  = $urandom_range(1, 4);
                y1 = y0 + h - 1;
                if ($urandom_range(0, 5) == 0 && w > 1) begin
                    t = x0; x0 = x1; x1 = t;
                end
                if (p == 0) ra = makeRect(x0, x1, y0, y1);
                else rb = makeRect(x0, x1, y0, y1);
            end
            applyStimulus(2'(mask), ra, rb);
            waitIdle("rand");
            checkStreams("rand", 1'b0);
        end
        pix_gap = 1'b0;
        idle_random = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
